branch_sequencer: RTL and testbench

//  Control-step sequencer for the conditional-branch instruction class (brzr/brnz/brpl/brmi).

---
 rtl/branch_sequencer_if.sv | 53 +++++
 rtl/branch_sequencer.sv | 142 ++++++++++++++
 tb/tb_branch_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Control bundle between the branch sequencer and its datapath.
// BRANCH_STATS_EN adds the taken/not-taken statistics counters.
interface branch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic Run;
  logic MemReady;
  logic BranchOut;
  logic PCout;
  logic MARin;
  logic IncPC;
  logic Zin;
  logic Zlowout;
  logic PCin;
  logic Read;
  logic MDRin;
  logic MDRout;
  logic IRin;
  logic Gra;
  logic Rout;
  logic CONin;
  logic Cout;
  logic Yin;
  logic ADD;
  logic Done;
  logic MemErr;
  logic [2:0] Step;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] TakenCnt;
  logic [CNT_W-1:0] NotTakenCnt;
`endif

  // Sequencer side: consumes Run/MemReady/BranchOut, drives everything else.
  modport master (
    input  Run, MemReady, BranchOut,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
    output MDRout, IRin, Gra, Rout, CONin, Cout, Yin, ADD,
    output Done, MemErr, Step
`ifdef BRANCH_STATS_EN
    , output TakenCnt, NotTakenCnt
`endif
  );

  modport slave (
    output Run, MemReady, BranchOut,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
    input  MDRout, IRin, Gra, Rout, CONin, Cout, Yin, ADD,
    input  Done, MemErr, Step
`ifdef BRANCH_STATS_EN
    , input TakenCnt, NotTakenCnt
`endif
  );
endinterface

// File: rtl/branch_sequencer.sv
// Fetch/execute step sequencer for conditional branches (brzr/brnz/brpl/brmi).
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic               Clock,
  input logic               Reset,
  branch_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, IDLE = 3'd7
  } state_t;

  localparam logic [8:0] TIMEOUT_L = 9'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [8:0] wait_inc;
  logic       mem_err_q, err_set;
  logic       done_q;

  assign wait_inc = {1'b0, wait_q} + 9'd1;

  // Step is the registered state, so it doubles as the FSM debug view.
  assign bus.Step   = state_q;
  assign bus.MemErr = mem_err_q;
  assign bus.Done   = done_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_set     = 1'b0;
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CONin   = 1'b0;
    bus.Cout    = 1'b0;
    bus.Yin     = 1'b0;
    bus.ADD     = 1'b0;
    case (state_q)
      IDLE: if (bus.Run && !mem_err_q) state_d = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = T1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = bus.MemReady;
        if (bus.MemReady) begin
          state_d = T2;
          wait_d  = 8'd0;
        end else if (wait_inc >= TIMEOUT_L) begin
          // Memory never answered: abandon the instruction without Done.
          state_d = IDLE;
          wait_d  = 8'd0;
          err_set = 1'b1;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = T3;
      end
      T3: begin
        bus.Gra   = 1'b1;
        bus.Rout  = 1'b1;
        bus.CONin = 1'b1;
        state_d   = T4;
      end
      T4: begin
        bus.PCout = 1'b1;
        bus.Yin   = 1'b1;
        state_d   = T5;
      end
      T5: begin
        bus.Cout = 1'b1;
        bus.ADD  = 1'b1;
        bus.Zin  = 1'b1;
        state_d  = T6;
      end
      T6: begin
        // Only the registered condition result reaches the strobes here.
        bus.Zlowout = bus.BranchOut;
        bus.PCin    = bus.BranchOut;
        state_d     = bus.Run ? T0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= (state_q == T6);
      if (err_set) mem_err_q <= 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q, not_taken_q;

  assign bus.TakenCnt    = taken_q;
  assign bus.NotTakenCnt = not_taken_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else if (state_q == T6) begin
      if (bus.BranchOut) begin
        if (taken_q != '1) taken_q <= taken_q + 1'b1;
      end else begin
        if (not_taken_q != '1) not_taken_q <= not_taken_q + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// Cycle-plan bench for branch_sequencer: instructions are described at the
// transaction level, expanded into per-cycle stimulus and expected outputs.
module tb_branch_sequencer;
  localparam int TO = 15;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic rst;
    logic run;
    logic mr;
    logic bo;
    logic chk;
  } stim_t;

  // Clock/reset block
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  branch_sequencer_if #(.CNT_W(CW)) bus ();

  branch_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Scoreboard: {step[24:22], strobes[21:6], done[5], memerr[4], taken[3:2], not_taken[1:0]}
  logic [24:0] exp_q[$];
  stim_t       stim_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  // Abstract model state: what the next pushed cycle must show.
  bit m_done_next = 0;
  bit m_err = 0;
  int m_tk = 0;
  int m_nt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Order: PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin Gra Rout CONin Cout Yin ADD
  function automatic logic [15:0] strobes_for(input int step, input bit mr, input bit bo);
    logic [15:0] s;
    s = 16'd0;
    case (step)
      0: begin s[15] = 1; s[14] = 1; s[13] = 1; s[12] = 1; end
      1: begin s[11] = 1; s[10] = 1; s[9] = 1; s[8] = mr; end
      2: begin s[7] = 1; s[6] = 1; end
      3: begin s[5] = 1; s[4] = 1; s[3] = 1; end
      4: begin s[15] = 1; s[1] = 1; end
      5: begin s[2] = 1; s[0] = 1; s[12] = 1; end
      6: begin s[11] = bo; s[10] = bo; end
      default: s = 16'd0;
    endcase
    return s;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input bit rst, input bit run, input bit mr, input bit bo,
                      input bit chk, input int step);
    stim_t s;
    s.rst = rst; s.run = run; s.mr = mr; s.bo = bo; s.chk = chk;
    stim_q.push_back(s);
    exp_q.push_back({3'(step), strobes_for(step, mr, bo), m_done_next, m_err,
                     2'(m_tk), 2'(m_nt)});
    m_done_next = 0;
    if (step == 6) begin
      m_done_next = 1;
      if (bo) m_tk = (m_tk < CMAX) ? m_tk + 1 : CMAX;
      else    m_nt = (m_nt < CMAX) ? m_nt + 1 : CMAX;
    end
    if (rst) begin
      m_done_next = 0;
      m_err = 0;
      m_tk = 0;
      m_nt = 0;
    end
  endtask

  task automatic add_idle(input int n, input bit run);
    for (int i = 0; i < n; i++) push(0, run, rb(), rb(), 1, 7);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) push(1, rb(), rb(), rb(), 0, 7);
  endtask

  // One branch instruction: w MemReady wait cycles, condition b, Run level in T6.
  task automatic add_instr(input bit from_idle, input int w, input bit b, input bit run_after);
    if (from_idle) push(0, 1, rb(), rb(), 1, 7);
    push(0, rb(), rb(), rb(), 1, 0);
    for (int i = 0; i < w; i++) push(0, rb(), 0, rb(), 1, 1);
    push(0, rb(), 1, rb(), 1, 1);
    for (int s = 2; s <= 5; s++) push(0, rb(), rb(), rb(), 1, s);
    push(0, run_after, rb(), b, 1, 6);
  endtask

  task automatic build_plan();
    bit idle;
    bit ra;
    add_reset(2);
    add_idle(2, 0);
    // Reset held three cycles starting in T4.
    push(0, 1, rb(), rb(), 1, 7);
    push(0, rb(), rb(), rb(), 1, 0);
    push(0, rb(), 1, rb(), 1, 1);
    for (int s = 2; s <= 3; s++) push(0, rb(), rb(), rb(), 1, s);
    add_reset(3);
    add_idle(2, 0);
    // Taken, not-taken back-to-back, delayed memory, then the longest legal wait.
    add_instr(1, 0, 1, 1);
    add_instr(0, 0, 0, 1);
    add_instr(0, 4, 1, 0);
    add_idle(2, 0);
    add_instr(1, TO - 1, 0, 0);
    add_idle(1, 0);
    // Randomized instruction stream.
    idle = 1;
    for (int k = 0; k < 14; k++) begin
      if (idle) add_idle($urandom_range(0, 2), 0);
      ra = rb();
      add_instr(idle, $urandom_range(0, 6), rb(), ra);
      idle = !ra;
    end
    if (!idle) add_instr(0, 1, 0, 0);
    add_idle(1, 0);
    // Counter saturation: five taken branches after a fresh reset.
    add_reset(1);
    for (int k = 0; k < 5; k++) add_instr(k == 0, $urandom_range(0, 2), 1, k != 4);
    add_idle(2, 0);
    // Memory timeout: MemErr sticks and Run is ignored until reset.
    push(0, 1, rb(), rb(), 1, 7);
    push(0, rb(), rb(), rb(), 1, 0);
    for (int i = 0; i < TO; i++) push(0, 1, 0, rb(), 1, 1);
    m_err = 1;
    add_idle(6, 1);
    add_reset(1);
    add_idle(1, 0);
    add_instr(1, 2, 1, 0);
    add_idle(2, 0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.MemReady = 1'b0;
    bus.BranchOut = 1'b0;
    build_plan();
    while (stim_q.size() > 0) begin
      stim_t s;
      logic [24:0] e;
      logic [15:0] obs_s;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge Clock);
      Reset = s.rst;
      bus.Run = s.run;
      bus.MemReady = s.mr;
      bus.BranchOut = s.bo;
      #1;
      if (s.chk) begin
        obs_s = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin,
                 bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Gra, bus.Rout,
                 bus.CONin, bus.Cout, bus.Yin, bus.ADD};
        check_eq("step", 32'(bus.Step), 32'(e[24:22]));
        check_eq("strobes", 32'(obs_s), 32'(e[21:6]));
        check_eq("done", 32'(bus.Done), 32'(e[5]));
        check_eq("memerr", 32'(bus.MemErr), 32'(e[4]));
`ifdef BRANCH_STATS_EN
        check_eq("taken_cnt", 32'(bus.TakenCnt), 32'(e[3:2]));
        check_eq("not_taken_cnt", 32'(bus.NotTakenCnt), 32'(e[1:0]));
`endif
      end
      cyc++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
